// File: rtl/servo_ramp.sv
// Servo command stage: degrees -> pulse counts, slewed by at most SLEW per frame; optional IDLE_RELEASE_EN drops en after RELEASE_FRAMES idle frames.
// Latency: outputs change only in the cycle after frame_tick; accept-to-first-change is 1..PERIOD+1 cycles.
// Backpressure: cmd_ready is low while MOVING and during reset; commands offered then are held off, not dropped.
module servo_ramp #(
    parameter int PERIOD         = 199999,
    parameter int MIN_PULSE      = 5000,
    parameter int STEP_PER_DEG   = 56,
    parameter int MAX_DEG        = 180,
    parameter int SLEW           = 500,
    parameter int RELEASE_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_deg,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [23:0] angle,
    output logic        en,
    output logic        busy,
    output logic        frame_tick
);

    localparam int CW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD);
    localparam logic [CW-1:0] CNT_PRE  = CW'(PERIOD - 1);
    localparam logic [23:0] MIN_P  = 24'(MIN_PULSE);
    localparam logic [23:0] STEP_C = 24'(STEP_PER_DEG);
    localparam logic [23:0] MAXD_C = 24'(MAX_DEG);
    localparam logic [23:0] SLEW_C = 24'(SLEW);

    // Parameter sets that cannot be represented are rejected at elaboration.
    if (PERIOD < 1 || RELEASE_FRAMES < 1 ||
        (longint'(MIN_PULSE) + longint'(MAX_DEG) * longint'(STEP_PER_DEG)) > 64'hFF_FFFF) begin : g_bad_params
        $error("servo_ramp: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_HOLD   = 2'd2,
        S_MOVING = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          tick_q;
    logic [23:0]   angle_q, angle_d;
    logic [23:0]   target_q, target_d;
    logic          en_q, en_d;

    logic          accept;
    logic [23:0]   deg_ext, deg_clamped, cmd_pw;
    logic          step_up, step_near;
    logic [23:0]   step_dist, step_next;

    // Frame counter; frame_tick is registered so it lines up with cnt == PERIOD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            tick_q <= (cnt_q == CNT_PRE);
        end
    end

    assign cmd_ready = rst_n && (state_q == S_IDLE || state_q == S_HOLD);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        deg_ext     = {16'd0, cmd_deg};
        deg_clamped = (deg_ext > MAXD_C) ? MAXD_C : deg_ext;
        cmd_pw      = MIN_P + deg_clamped * STEP_C;
    end

    // Unsigned magnitude compare avoids a signed subtract on the 24-bit path.
    always_comb begin
        step_up   = (target_q >= angle_q);
        step_dist = step_up ? (target_q - angle_q) : (angle_q - target_q);
        step_near = (step_dist <= SLEW_C);
        if (step_near) begin
            step_next = target_q;
        end else if (step_up) begin
            step_next = angle_q + SLEW_C;
        end else begin
            step_next = angle_q - SLEW_C;
        end
    end

`ifdef IDLE_RELEASE_EN
    localparam int RW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_FRAMES - 1);
    logic [RW-1:0] rel_q, rel_d;
`endif

    always_comb begin
        state_d  = state_q;
        angle_d  = angle_q;
        target_d = target_q;
        en_d     = en_q;
`ifdef IDLE_RELEASE_EN
        rel_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                if (accept) begin
                    target_d = cmd_pw;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tick_q) begin
                    angle_d = target_q;
                    en_d    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    target_d = cmd_pw;
                    state_d  = S_MOVING;
                end
`ifdef IDLE_RELEASE_EN
                else if (tick_q) begin
                    if (rel_q == REL_LAST) begin
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                end else begin
                    rel_d = rel_q;
                end
`endif
            end
            S_MOVING: begin
                if (tick_q) begin
                    angle_d = step_next;
                    if (step_near) begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            angle_q  <= '0;
            target_q <= '0;
            en_q     <= 1'b0;
`ifdef IDLE_RELEASE_EN
            rel_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            angle_q  <= angle_d;
            target_q <= target_d;
            en_q     <= en_d;
`ifdef IDLE_RELEASE_EN
            rel_q    <= rel_d;
`endif
        end
    end

    assign angle      = angle_q;
    assign en         = en_q;
    assign busy       = (state_q == S_MOVING);
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a short frame (PERIOD=99): table of HOLD moves plus corner sequences.
module tb_servo_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_deg;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] angle;
    logic        en;
    logic        busy;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    servo_ramp #(
        .PERIOD(99), .MIN_PULSE(5000), .STEP_PER_DEG(56),
        .MAX_DEG(180), .SLEW(500), .RELEASE_FRAMES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_deg(cmd_deg), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .angle(angle), .en(en), .busy(busy),
        .frame_tick(frame_tick)
    );

    typedef struct {
        logic [7:0] deg;
        int         exp_ang;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advances to the negedge of the next frame_tick cycle.
    task automatic wait_tick();
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (frame_tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    // Called at a negedge; offers one command for one cycle.
    task automatic send(input logic [7:0] d, output int acc);
        cmd_deg   = d;
        cmd_valid = 1'b1;
        acc       = int'(cmd_ready);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int acc, n, p, e, t, ready_seen, stable;

    initial begin
        vecs[0] = '{8'd0,   5000,  11};
        vecs[1] = '{8'd250, 15080, 21};
        vecs[2] = '{8'd180, 15080, 1};
        vecs[3] = '{8'd100, 10600, 9};
        vecs[4] = '{8'd101, 10656, 1};
        vecs[5] = '{8'd255, 15080, 9};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_deg = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_angle", int'(angle), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(cmd_ready), 1);

        wait_tick();
        n = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            n++;
            if (frame_tick) break;
        end
        chk("frame_len", n, 100);

        // First command snaps through LOAD without ramping.
        @(negedge clk);
        send(8'd90, acc);
        chk("load_acc", acc, 1);
        chk("load_en_wait", int'(en), 0);
        chk("load_angle_wait", int'(angle), 0);
        wait_tick();
        @(negedge clk);
        chk("load_angle", int'(angle), 10040);
        chk("load_en", int'(en), 1);
        chk("load_busy", int'(busy), 0);
        chk("load_ready", int'(cmd_ready), 1);

        foreach (vecs[k]) begin
            send(vecs[k].deg, acc);
            chk("vec_acc", acc, 1);
            chk("vec_busy", int'(busy), 1);
            chk("vec_ready", int'(cmd_ready), 0);
            t = vecs[k].exp_ang;
            n = 0;
            for (int i = 0; i < 60; i++) begin
                p = int'(angle);
                wait_tick();
                @(negedge clk);
                n++;
                if ((t >= p ? t - p : p - t) <= 500) e = t;
                else e = (t > p) ? p + 500 : p - 500;
                chk("ramp_step", int'(angle), e);
                chk("ramp_busy", int'(busy), int'(angle != 24'(t)));
                if (!busy) break;
            end
            chk("vec_angle", int'(angle), t);
            chk("vec_ticks", n, vecs[k].exp_ticks);
            chk("vec_en", int'(en), 1);
        end

        // Command held valid through MOVING is only taken once HOLD is reached.
        send(8'd170, acc);
        chk("mv_acc", acc, 1);
        cmd_deg = 8'd10; cmd_valid = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            if (cmd_ready) ready_seen = 1;
            @(negedge clk);
        end
        chk("mv_ready_blocked", ready_seen, 0);
        chk("mv_target_kept", int'(angle), 14520);
        chk("mv_hold_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mv_late_accept", int'(busy), 1);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("mv_final", int'(angle), 5560);

        // Acceptance in the tick cycle: a full frame passes before the first step.
        wait_tick();
        cmd_deg = 8'd20; cmd_valid = 1'b1;
        acc = int'(cmd_ready);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("tk_acc", acc, 1);
        chk("tk_busy", int'(busy), 1);
        stable = 1;
        for (int i = 0; i < 250; i++) begin
            if (angle != 24'd5560) stable = 0;
            if (frame_tick) break;
            @(negedge clk);
        end
        chk("tk_stable", stable, 1);
        @(negedge clk);
        chk("tk_first_step", int'(angle), 6060);
        wait_tick();
        @(negedge clk);
        chk("tk_done", int'(angle), 6120);
        chk("tk_busy_done", int'(busy), 0);

        // Reset in the middle of a ramp.
        send(8'd90, acc);
        wait_tick();
        wait_tick();
        @(negedge clk);
        chk("mr_mid", int'(angle), 7120);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_angle", int'(angle), 0);
        chk("mr_en", int'(en), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_ready_after", int'(cmd_ready), 1);
        chk("mr_angle_after", int'(angle), 0);

`ifdef IDLE_RELEASE_EN
        send(8'd45, acc);
        wait_tick();
        @(negedge clk);
        chk("rel_load", int'(angle), 7520);
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            @(negedge clk);
            chk("rel_en", int'(en), (k < 3) ? 1 : 0);
        end
        chk("rel_angle", int'(angle), 7520);
        chk("rel_ready", int'(cmd_ready), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
